// File: rtl/da_ctrl.sv
// da_ctrl: maps 0.1 mV amplitudes to 12-bit DAC codes paced by a prescaler tick; DA_BIT_REVERSE_EN reverses pin order
module da_ctrl #(
    parameter int UPD_DIV = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        clk_to_DA,
    output logic [11:0] data_to_DA,
    output logic        da_update
);
    typedef enum logic [1:0] {IDLE, CALC, WAIT} state_t;
    state_t state, state_nx;
    logic [15:0] presc;
    logic        tick;
    logic        accept;
    logic        done;
    logic [14:0] value;
    logic [26:0] rem;
    logic [26:0] dvs;
    logic [27:0] diff;
    logic [12:0] q;
    logic [3:0]  cnt;
    logic [11:0] code;
    logic [11:0] pins;
    assign tick       = presc == 16'(UPD_DIV - 1);
    assign data_ready = rst_n && state == IDLE;
    assign accept     = data_valid && data_ready;
    assign done       = cnt == 4'd12;
    assign value      = data_in > 16'd20000 ? 15'd20000 : data_in[14:0];
    assign diff       = {1'b0, rem} - {1'b0, dvs};
    assign code       = q[12] ? 12'hFFF : q[11:0];
    assign clk_to_DA  = ~clk;
`ifdef DA_BIT_REVERSE_EN
    assign pins = {<<{code}};
`else
    assign pins = code;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = accept                     ? CALC :
                   (state == CALC && done)    ? WAIT :
                   (state == WAIT && tick)    ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            rem        <= '0;
            dvs        <= '0;
            q          <= '0;
            cnt        <= '0;
            data_to_DA <= '0;
            da_update  <= 1'b0;
        end else begin
            presc     <= tick ? 16'd0 : presc + 16'd1;
            da_update <= state == WAIT && tick;
            if (accept) begin
                rem <= {value, 12'd0};
                dvs <= 27'd81920000;
                q   <= '0;
                cnt <= '0;
            end else if (state == CALC) begin
                rem <= diff[27] ? rem : diff[26:0];
                q   <= {q[11:0], ~diff[27]};
                dvs <= dvs >> 1;
                cnt <= cnt + 4'd1;
            end
            if (state == WAIT && tick) data_to_DA <= pins;
        end
    end
endmodule

// File: tb/tb_da_ctrl.sv
// tb_da_ctrl: directed checks of da_ctrl with UPD_DIV=20 against hand-computed codes and tick-aligned latencies
module tb_da_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        clk_to_DA;
    logic [11:0] data_to_DA;
    logic        da_update;
    int checks = 0;
    int errors = 0;
    int presc_m = 0;

    da_ctrl #(.UPD_DIV(20)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .clk_to_DA(clk_to_DA), .data_to_DA(data_to_DA), .da_update(da_update)
    );

    always #5 clk = ~clk;

    always @(posedge clk) presc_m <= !rst_n ? 0 : (presc_m == 19 ? 0 : presc_m + 1);

    function automatic logic [11:0] pin(input logic [11:0] c);
        logic [11:0] r;
`ifdef DA_BIT_REVERSE_EN
        for (int i = 0; i < 12; i++) r[11-i] = c[i];
`else
        r = c;
`endif
        return r;
    endfunction

    task automatic align(input int p);
        for (int i = 0; i < 40 && presc_m != p; i++) @(negedge clk);
        checks++;
        if (presc_m != p) begin
            errors++;
            $display("FAIL align: prescaler model %0d want %0d", presc_m, p);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", data_ready); end
        checks++; if (data_to_DA !== 12'h000) begin errors++; $display("FAIL rst_data: got %h want 000", data_to_DA); end
        checks++; if (da_update !== 1'b0) begin errors++; $display("FAIL rst_update: got %b want 0", da_update); end
        checks++; if (clk_to_DA !== 1'b1) begin errors++; $display("FAIL rst_clkda_low: got %b want 1", clk_to_DA); end
        @(posedge clk); #1;
        checks++; if (clk_to_DA !== 1'b0) begin errors++; $display("FAIL rst_clkda_high: got %b want 0", clk_to_DA); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", data_ready); end
    endtask

    task automatic test_abort;
        int n;
        @(negedge clk);
        data_in = 16'd15000;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_low: got %b want 0", data_ready); end
        checks++; if (dut.presc !== 16'd0) begin errors++; $display("FAIL abort_presc: got %0d want 0", dut.presc); end
        rst_n = 1'b1;
        #1;
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", data_ready); end
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (da_update) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL abort_updates: got %0d want 0", n); end
        checks++; if (data_to_DA !== 12'h000) begin errors++; $display("FAIL abort_data: got %h want 000", data_to_DA); end
    endtask

    task automatic send(input logic [15:0] v, input logic [11:0] c, input int p, input string nm);
        int m, k;
        bit got;
        align(p);
        data_in = v;
        data_valid = 1'b1;
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1", nm, data_ready); end
        m = 14;
        while ((p + m) % 20 != 19) m++;
        k = 0;
        got = 0;
        while (!got && k < 60) begin
            @(negedge clk);
            k++;
            data_valid = 1'b0;
            if (k == 1) begin
                checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b want 0", nm, data_ready); end
            end
            if (da_update) got = 1;
        end
        checks++; if (!got || k != m + 1) begin errors++; $display("FAIL %s_latency: got %0d want %0d", nm, k, m + 1); end
        checks++; if (data_to_DA !== pin(c)) begin errors++; $display("FAIL %s_code: got %h want %h", nm, data_to_DA, pin(c)); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after: got %b want 1", nm, data_ready); end
        @(negedge clk);
        checks++; if (da_update !== 1'b0) begin errors++; $display("FAIL %s_pulse_width: got %b want 0", nm, da_update); end
        checks++; if (data_to_DA !== pin(c)) begin errors++; $display("FAIL %s_hold: got %h want %h", nm, data_to_DA, pin(c)); end
    endtask

    task automatic test_mapping;
        send(16'd10000, 12'd2048, 5, "half");
        send(16'd0, 12'd0, 6, "zero");
        send(16'd5, 12'd1, 0, "lsb");
        send(16'd20000, 12'd4095, 12, "full");
        send(16'd65535, 12'd4095, 3, "sat");
    endtask

    task automatic test_ignore;
        int n, kk;
        align(5);
        data_in = 16'd10000;
        data_valid = 1'b1;
        n = 0;
        kk = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) data_valid = 1'b0;
            if (k == 3) begin
                data_in = 16'd3000;
                data_valid = 1'b1;
                checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL ign_ready: got %b want 0", data_ready); end
            end
            if (k == 8) data_valid = 1'b0;
            if (da_update) begin
                n++;
                if (n == 1) kk = k;
            end
        end
        checks++; if (n != 1) begin errors++; $display("FAIL ign_count: got %0d want 1", n); end
        checks++; if (kk != 15) begin errors++; $display("FAIL ign_latency: got %0d want 15", kk); end
        checks++; if (data_to_DA !== pin(12'd2048)) begin errors++; $display("FAIL ign_code: got %h want %h", data_to_DA, pin(12'd2048)); end
    endtask

    task automatic test_back_to_back;
        int n, idx;
        int t[4];
        logic [11:0] v[4];
        bit flag;
        align(0);
        data_in = 16'd4000;
        data_valid = 1'b1;
        idx = 0;
        n = 0;
        flag = data_valid && data_ready;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (flag) begin
                idx++;
                if (idx == 1) data_in = 16'd8000;
                if (idx == 2) data_valid = 1'b0;
            end
            flag = data_valid && data_ready;
            if (da_update) begin
                if (n < 4) begin
                    t[n] = cyc;
                    v[n] = data_to_DA;
                end
                n++;
            end
        end
        checks++; if (idx != 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", idx); end
        checks++; if (n != 2) begin errors++; $display("FAIL b2b_updates: got %0d want 2", n); end
        if (n >= 2) begin
            checks++; if (t[0] != 20) begin errors++; $display("FAIL b2b_first_time: got %0d want 20", t[0]); end
            checks++; if (t[1] - t[0] != 20) begin errors++; $display("FAIL b2b_spacing: got %0d want 20", t[1] - t[0]); end
            checks++; if (v[0] !== pin(12'd819)) begin errors++; $display("FAIL b2b_code0: got %h want %h", v[0], pin(12'd819)); end
            checks++; if (v[1] !== pin(12'd1638)) begin errors++; $display("FAIL b2b_code1: got %h want %h", v[1], pin(12'd1638)); end
        end
    endtask

    initial begin
        test_reset;
        test_abort;
        test_mapping;
        test_ignore;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/da_ctrl.md
DA_CTRL -- requirements
Module: da_ctrl

Interface
REQ-001 Parameter UPD_DIV, default 50, DAC update period in clk cycles (legal 2..65535); at 50 MHz the default gives 1 MSPS.
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst_n  input  1  reset; the block has one clock, and reset is synchronous and active-low.
REQ-004 data_in  input  16  requested amplitude in 0.1 mV units, full scale 20000 = 2000 mV (same scaling as the AD path output).
REQ-005 data_valid  input  1  data_in is valid this cycle.
REQ-006 data_ready  output  1  block accepts data_in this cycle.
REQ-007 clk_to_DA  output  1  DAC clock, equal to ~clk, so the DAC samples mid-period of data_to_DA.
REQ-008 data_to_DA  output  12  DAC code pins, registered.
REQ-009 da_update  output  1  one-cycle pulse, high in the cycle data_to_DA takes a new value.

Function
REQ-010 The FSM SHALL have the states IDLE, CALC and WAIT.
REQ-011 data_ready SHALL be 1 only in IDLE; the transfer occurs on the edge where data_valid=1 and data_ready=1, with transition to CALC.
REQ-012 On accept, the block SHALL saturate the operand: value = min(data_in, 20000).
REQ-013 CALC SHALL compute q = floor(value*4096/20000) with a restoring divider producing one quotient bit per cycle, MSB first, over a 27-bit dividend and a 13-bit quotient.
REQ-014 CALC SHALL last exactly 13 cycles and then go to WAIT.
REQ-015 The code SHALL be min(q, 4095), so value 20000 gives 4095.
REQ-016 A free-running prescaler SHALL count 0..UPD_DIV-1 and wrap to 0.
REQ-017 tick SHALL be high when the prescaler equals UPD_DIV-1; the prescaler runs in all states.
REQ-018 In WAIT, on the first edge with tick=1, data_to_DA SHALL load the mapped code, da_update SHALL pulse for one cycle, and the state SHALL return to IDLE.
REQ-019 WAIT SHALL hold indefinitely otherwise.
REQ-020 If tick occurs in the cycle CALC completes, the block SHALL NOT use it; WAIT waits for the next tick.
REQ-021 data_valid while data_ready=0 SHALL be ignored (no queueing); the upstream block holds or drops it.
REQ-022 Between updates data_to_DA SHALL hold its last value.
REQ-023 The accept-to-output latency SHALL be 14 + (cycles until the next tick) clock cycles.
REQ-024 The maximum accepted rate SHALL be one sample per tick period when UPD_DIV >= 15, and one per 15+ cycles otherwise.

Reset
REQ-025 While rst_n=0 at a clk edge: state IDLE, prescaler 0, divider registers 0, data_to_DA 12'h000, da_update 0.
REQ-026 data_ready SHALL be 0 while rst_n is low and 1 from the first cycle after release.
REQ-027 Reset during CALC or WAIT SHALL abort the conversion; the aborted value never reaches data_to_DA.
REQ-028 clk_to_DA SHALL toggle during reset.

Configuration
REQ-029 The macro DA_BIT_REVERSE_EN SHALL select the pin mapping.
REQ-030 With DA_BIT_REVERSE_EN defined: data_to_DA[11-i] = code[i] for i=0..11, matching the reversed board wiring of the AD channel.
REQ-031 Without DA_BIT_REVERSE_EN: data_to_DA = code, straight.
REQ-032 Timing and all other behaviour SHALL be identical with or without DA_BIT_REVERSE_EN.

Verification (UPD_DIV=20, DA_BIT_REVERSE_EN defined unless noted)
REQ-033 data_in=10000 accepted -> code 2048; data_to_DA=12'h001 at the first tick after 13 CALC cycles; da_update high one cycle; data_ready back to 1 the next cycle.
REQ-034 data_in=0 -> 12'h000; data_in=5 -> code 1 -> 12'h800; data_in=20000 -> 12'hFFF; data_in=65535 -> saturated, 12'hFFF.
REQ-035 Without DA_BIT_REVERSE_EN: data_in=10000 -> 12'h800; data_in=5 -> 12'h001.
REQ-036 Second data_valid pulse with data_in=3000, held 5 cycles, during CALC -> ignored; data_to_DA reflects only the first value and no second da_update occurs.
REQ-037 rst_n low for 1 cycle at CALC cycle 6 of data_in=15000 -> data_to_DA stays 12'h000, no da_update, prescaler restarts from 0, and data_ready=1 the next cycle.
REQ-038 Back-to-back valid held high with values 4000, 8000 -> exactly one da_update per tick (every 20 cycles), codes 819 then 1638, output reversed.
